bus_arbiter: RTL
================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter RAM_WAIT, default 1, giving the RAM read wait states (0 or 1) per DMA access.
REQ-002 SHALL have parameter MAX_BURST, default 16, giving the maximum DMA words per grant (ARB_FAIRNESS_EN only).
REQ-003 SHALL have parameter CPU_SLOTS, default 8, giving the forced CPU-ownership cycles after a full burst (ARB_FAIRNESS_EN only).
REQ-004 Ports (name  dir  width  meaning):
  clk  in  1  sole clock, rising edge
  reset  in  1  asynchronous, active-low reset
  cpu_address  in  16  CPU bus address
  cpu_data_out  in  16  CPU write data
  cpu_write  in  1  CPU write strobe
  cpu_busy  in  1  CPU parked in opcode-select stage under hold
  cpu_hold  out  1  stall request to CPU
  dma_req  in  1  DMA word request, level
  dma_addr  in  16  DMA word address
  dma_we  in  1  DMA write (1) or read (0)
  dma_wdata  in  16  DMA write data
  dma_ack  out  1  one-cycle word-complete pulse
  dma_rdata  out  16  DMA read data, valid while dma_ack=1
  dma_grant  out  1  DMA owns the bus
  mem_addr  out  16  RAM address
  mem_wdata  out  16  RAM write data
  mem_we  out  1  RAM write enable
  mem_rdata  in  16  RAM read data, also fed directly to CPU data_in

Function
REQ-005 SHALL implement states CPU_OWN, HOLD_WAIT, DMA_XFER, DMA_NEXT and, with ARB_FAIRNESS_EN, COOLDOWN.
REQ-006 In CPU_OWN, COOLDOWN and HOLD_WAIT, mem_addr/mem_wdata/mem_we SHALL equal cpu_address/cpu_data_out/cpu_write combinationally.
REQ-007 In CPU_OWN, dma_req=1 SHALL set cpu_hold=1 and enter HOLD_WAIT on the next edge.
REQ-008 In HOLD_WAIT, cpu_busy=1 with cpu_write=0 SHALL enter DMA_XFER (dma_grant=1); dma_req=0 SHALL return to CPU_OWN and clear cpu_hold.
REQ-009 On entry to DMA_XFER (cycle G), the block SHALL register dma_addr, dma_wdata and dma_we into mem_addr, mem_wdata and mem_we; mem_we SHALL be high in cycle G only.
REQ-010 dma_ack SHALL pulse high in cycle G+RAM_WAIT+1 with dma_rdata = mem_rdata captured at that edge; dma_rdata SHALL hold its value otherwise.
REQ-011 Requester rule: dma_addr, dma_we and dma_wdata SHALL be held stable from dma_req rise until dma_ack; dma_req falling mid-access SHALL NOT abort the access, and the ack is still issued.
REQ-012 After ack (DMA_NEXT): dma_req=1 SHALL start the next word in DMA_XFER on the next edge, back-to-back; dma_req=0 SHALL return to CPU_OWN with cpu_hold=0 and dma_grant=0 in that same transition.
REQ-013 cpu_hold SHALL stay 1 continuously from HOLD_WAIT entry until exit of DMA_NEXT.
REQ-014 dma_grant SHALL be 1 only in DMA_XFER and DMA_NEXT; the CPU SHALL never drive RAM while dma_grant=1.
REQ-015 Word counter SHALL be 16 bits, SHALL count acks per grant, and SHALL clear on each grant.

Reset
REQ-016 reset low SHALL asynchronously force CPU_OWN, cpu_hold=0, dma_ack=0, dma_grant=0, dma_rdata=0, registered mem_we=0, and counters to 0, aborting any in-flight DMA word without ack.
REQ-017 Operation SHALL resume on the first rising clk edge after reset deasserts.

Configuration
REQ-018 Macro ARB_FAIRNESS_EN defined: when the ack count reaches MAX_BURST, the block SHALL enter COOLDOWN, clear cpu_hold and dma_grant, stay CPU_SLOTS cycles, then go to HOLD_WAIT if dma_req=1, else CPU_OWN.
REQ-019 Macro ARB_FAIRNESS_EN undefined: COOLDOWN, MAX_BURST and CPU_SLOTS SHALL have no effect, and DMA SHALL keep the bus as long as dma_req remains 1.

Verification
REQ-020 Idle: cpu_address=0x8000, cpu_write=0, dma_req=0 -> mem_addr=0x8000, cpu_hold=0, dma_grant=0.
REQ-021 Single read, RAM_WAIT=1: dma_req=1, addr=0x0040, we=0, cpu_busy rises 2 cycles later -> grant, then ack exactly 2 cycles after grant with dma_rdata=RAM[0x0040]; hold drops after dma_req=0.
REQ-022 Write: dma_addr=0x0100, wdata=0xBEEF, we=1 -> mem_we high exactly one cycle at 0x0100; RAM[0x0100]=0xBEEF.
REQ-023 Fairness on, MAX_BURST=4, CPU_SLOTS=8, dma_req held -> 4 acks, hold low for 8 cycles, then new grant; with fairness off -> acks continue uninterrupted.
REQ-024 dma_req dropped during HOLD_WAIT -> no grant, cpu_hold low next cycle, no mem_we.
REQ-025 reset low in cycle G+1 of a write -> dma_ack never pulses, state CPU_OWN, cpu_hold=0 immediately.

Source files
------------

// File: rtl/bus_arbiter.sv
// bus_arbiter: arbitrates a single-port RAM between a CPU and a DMA requester.
// The CPU owns the RAM by default. A DMA request stalls the CPU through
// cpu_hold. Once the CPU parks, DMA words are transferred one at a time with a
// one-cycle dma_ack per word. Consecutive words run back to back while
// dma_req stays high.
// Optional build macro: ARB_FAIRNESS_EN. When defined, every MAX_BURST words
// the bus is handed back to the CPU for CPU_SLOTS cycles.
module bus_arbiter #(
  parameter int RAM_WAIT  = 1,
  parameter int MAX_BURST = 16,
  parameter int CPU_SLOTS = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cpu_address,
  input  logic [15:0] cpu_data_out,
  input  logic        cpu_write,
  input  logic        cpu_busy,
  output logic        cpu_hold,
  input  logic        dma_req,
  input  logic [15:0] dma_addr,
  input  logic        dma_we,
  input  logic [15:0] dma_wdata,
  output logic        dma_ack,
  output logic [15:0] dma_rdata,
  output logic        dma_grant,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_we,
  input  logic [15:0] mem_rdata
);

  typedef enum logic [2:0] {
    CPU_OWN   = 3'd0,
    HOLD_WAIT = 3'd1,
    DMA_XFER  = 3'd2,
    DMA_NEXT  = 3'd3,
    COOLDOWN  = 3'd4
  } state_t;

  // Value of the wait-state counter in the last DMA_XFER cycle of a word.
  localparam logic WAIT_LAST = (RAM_WAIT != 0);

  state_t      state_q, state_d;
  logic        cpu_hold_q, cpu_hold_d;
  logic        dma_grant_q, dma_grant_d;
  logic        dma_ack_q, dma_ack_d;
  logic [15:0] dma_rdata_q, dma_rdata_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic [15:0] mem_wdata_q, mem_wdata_d;
  logic        mem_we_q, mem_we_d;
  logic        wait_q, wait_d;
  logic [15:0] word_cnt_q, word_cnt_d;
  logic [15:0] cool_cnt_q, cool_cnt_d;
  logic        burst_done;
  logic        cpu_owns_bus;

`ifdef ARB_FAIRNESS_EN
  // A grant is cut short once it has delivered MAX_BURST acknowledged words.
  assign burst_done = (word_cnt_q == 16'(MAX_BURST));
`else
  // Without fairness a grant lasts as long as the requester keeps dma_req high.
  logic unused_max_burst;
  assign burst_done       = 1'b0;
  assign unused_max_burst = ^MAX_BURST;
`endif

  // Next-state and next-output logic for the arbitration FSM.
  always_comb begin
    state_d     = state_q;
    cpu_hold_d  = cpu_hold_q;
    dma_grant_d = dma_grant_q;
    dma_ack_d   = 1'b0;
    dma_rdata_d = dma_rdata_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;
    wait_d      = wait_q;
    word_cnt_d  = word_cnt_q;
    cool_cnt_d  = cool_cnt_q;

    case (state_q)
      CPU_OWN: begin
        if (dma_req) begin
          state_d    = HOLD_WAIT;
          cpu_hold_d = 1'b1;
        end
      end

      HOLD_WAIT: begin
        if (!dma_req) begin
          state_d    = CPU_OWN;
          cpu_hold_d = 1'b0;
        end else if (cpu_busy && !cpu_write) begin
          state_d     = DMA_XFER;
          dma_grant_d = 1'b1;
          mem_addr_d  = dma_addr;
          mem_wdata_d = dma_wdata;
          mem_we_d    = dma_we;
          wait_d      = 1'b0;
          word_cnt_d  = 16'd0;
        end
      end

      DMA_XFER: begin
        if (wait_q == WAIT_LAST) begin
          state_d     = DMA_NEXT;
          dma_ack_d   = 1'b1;
          dma_rdata_d = mem_rdata;
          word_cnt_d  = word_cnt_q + 16'd1;
        end else begin
          wait_d = 1'b1;
        end
      end

      DMA_NEXT: begin
        if (burst_done) begin
          state_d     = COOLDOWN;
          cpu_hold_d  = 1'b0;
          dma_grant_d = 1'b0;
          cool_cnt_d  = 16'(CPU_SLOTS - 1);
        end else if (dma_req) begin
          state_d     = DMA_XFER;
          mem_addr_d  = dma_addr;
          mem_wdata_d = dma_wdata;
          mem_we_d    = dma_we;
          wait_d      = 1'b0;
        end else begin
          state_d     = CPU_OWN;
          cpu_hold_d  = 1'b0;
          dma_grant_d = 1'b0;
        end
      end

      COOLDOWN: begin
        if (cool_cnt_q == 16'd0) begin
          if (dma_req) begin
            state_d    = HOLD_WAIT;
            cpu_hold_d = 1'b1;
          end else begin
            state_d = CPU_OWN;
          end
        end else begin
          cool_cnt_d = cool_cnt_q - 16'd1;
        end
      end

      default: begin
        state_d     = CPU_OWN;
        cpu_hold_d  = 1'b0;
        dma_grant_d = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset abandons any word still in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= CPU_OWN;
      cpu_hold_q  <= 1'b0;
      dma_grant_q <= 1'b0;
      dma_ack_q   <= 1'b0;
      dma_rdata_q <= 16'd0;
      mem_addr_q  <= 16'd0;
      mem_wdata_q <= 16'd0;
      mem_we_q    <= 1'b0;
      wait_q      <= 1'b0;
      word_cnt_q  <= 16'd0;
      cool_cnt_q  <= 16'd0;
    end else begin
      state_q     <= state_d;
      cpu_hold_q  <= cpu_hold_d;
      dma_grant_q <= dma_grant_d;
      dma_ack_q   <= dma_ack_d;
      dma_rdata_q <= dma_rdata_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      wait_q      <= wait_d;
      word_cnt_q  <= word_cnt_d;
      cool_cnt_q  <= cool_cnt_d;
    end
  end

  // The CPU keeps its direct path to RAM until a DMA word is actually granted.
  assign cpu_owns_bus = (state_q == CPU_OWN) || (state_q == HOLD_WAIT) ||
                        (state_q == COOLDOWN);

  assign mem_addr  = cpu_owns_bus ? cpu_address  : mem_addr_q;
  assign mem_wdata = cpu_owns_bus ? cpu_data_out : mem_wdata_q;
  assign mem_we    = cpu_owns_bus ? cpu_write    : mem_we_q;

  assign cpu_hold  = cpu_hold_q;
  assign dma_grant = dma_grant_q;
  assign dma_ack   = dma_ack_q;
  assign dma_rdata = dma_rdata_q;

endmodule
